// File: rtl/mul_wide_seq.sv
// mul_wide_seq: sequential WIDTH x WIDTH -> 2*WIDTH multiplier.
// One 16x16 unsigned limb multiplier is reused across all N*N limb pairs.
// The operands are converted to magnitudes at accept, and the sign is applied at the end.
// Optional feature: define MUL_WIDE_SEQ_ZERO_SKIP_EN to send a zero operand
// straight to FIX, which gives a two-cycle result of 0.
module mul_wide_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 a_signed,
  input  logic                 b_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   dout
);

  localparam int N  = WIDTH / 16;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, MUL, FIX, DONE} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     ma_q, ma_d, mb_q, mb_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [IW-1:0]        i_q, i_d, j_q, j_d;
  logic [2*WIDTH-1:0]   dout_q, dout_d;
  logic                 out_valid_q, out_valid_d;

  logic                 a_neg, b_neg;
  logic [15:0]          limb_a, limb_b;
  logic [31:0]          prod;
  logic [IW:0]          ij_sum;
  logic [2*WIDTH-1:0]   prod_sh;

  assign a_neg = a_signed & a[WIDTH-1];
  assign b_neg = b_signed & b[WIDTH-1];

  // Limb product for the current (i, j) pair, aligned to 16*(i+j).
  always_comb begin
    limb_a  = ma_q[{i_q, 4'b0000} +: 16];
    limb_b  = mb_q[{j_q, 4'b0000} +: 16];
    prod    = limb_a * limb_b;
    ij_sum  = {1'b0, i_q} + {1'b0, j_q};
    prod_sh = (2*WIDTH)'(prod) << {ij_sum, 4'b0000};
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    i_d         = i_q;
    j_d         = j_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // The most negative value negates to itself, so its unsigned magnitude is already correct.
          ma_d    = a_neg ? (~a + WIDTH'(1)) : a;
          mb_d    = b_neg ? (~b + WIDTH'(1)) : b;
          neg_d   = a_neg ^ b_neg;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = MUL;
`ifdef MUL_WIDE_SEQ_ZERO_SKIP_EN
          if (ma_d == '0 || mb_d == '0) begin
            neg_d   = 1'b0;
            state_d = FIX;
          end
`endif
        end
      end
      MUL: begin
        acc_d = acc_q + prod_sh;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            i_d     = '0;
            state_d = FIX;
          end else begin
            i_d = i_q + IW'(1);
          end
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      FIX: begin
        dout_d      = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset drops any in-flight transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ma_q        <= '0;
      mb_q        <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      j_q         <= j_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign dout      = dout_q;

endmodule

// File: tb/tb_mul_wide_seq.sv
// Directed bench for mul_wide_seq at WIDTH 16, 32 and 64.
module tb_mul_wide_seq;

  logic         clock, reset;
  logic         a_signed, b_signed, out_ready;
  logic         iv32, ir32, ov32;
  logic [31:0]  a32, b32;
  logic [63:0]  d32;
  logic         iv16, ir16, ov16;
  logic [15:0]  a16, b16;
  logic [31:0]  d16;
  logic         iv64, ir64, ov64;
  logic [63:0]  a64, b64;
  logic [127:0] d64;

  int tests = 0;
  int fails = 0;
  int lat;
  int zlat;

  mul_wide_seq #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .a_signed(a_signed), .b_signed(b_signed),
    .out_valid(ov32), .out_ready(out_ready), .dout(d32));

  mul_wide_seq #(.WIDTH(16)) dut16 (
    .clock(clock), .reset(reset), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .a_signed(a_signed), .b_signed(b_signed),
    .out_valid(ov16), .out_ready(out_ready), .dout(d16));

  mul_wide_seq #(.WIDTH(64)) dut64 (
    .clock(clock), .reset(reset), .in_valid(iv64), .in_ready(ir64),
    .a(a64), .b(b64), .a_signed(a_signed), .b_signed(b_signed),
    .out_valid(ov64), .out_ready(out_ready), .dout(d64));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept one operand pair on dut32 and wait for out_valid.
  // The returned lat is the cycle count, where the accept cycle is cycle 0.
  task automatic accept32(input logic [31:0] av, input logic [31:0] bv,
                          input logic as, input logic bs, output int l);
    @(negedge clock);
    a32 = av; b32 = bv; a_signed = as; b_signed = bs; iv32 = 1'b1;
    @(posedge clock); #1;
    iv32 = 1'b0; a32 = '0; b32 = '0;
    l = 1;
    while (!ov32 && l < 200) begin
      @(posedge clock); #1;
      l++;
    end
  endtask

  // Run a full transaction with out_ready high, then check the return to idle.
  task automatic run32(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic as, input logic bs, input logic [63:0] exp, input int elat);
    int l;
    accept32(av, bv, as, bs, l);
    chk({tag, "_lat"}, 128'(l), 128'(elat));
    chk({tag, "_dout"}, 128'(d32), 128'(exp));
    @(posedge clock); #1;
    chk({tag, "_idle"}, 128'({ov32, ir32}), 128'(2'b01));
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b1; a_signed = 1'b0; b_signed = 1'b0;
    iv32 = 1'b0; a32 = '0; b32 = '0;
    iv16 = 1'b0; a16 = '0; b16 = '0;
    iv64 = 1'b0; a64 = '0; b64 = '0;
    #12;
    chk("rst_ready", 128'({ir32, ir16, ir64}), 128'(3'b111));
    chk("rst_valid", 128'({ov32, ov16, ov64}), 128'(3'b000));
    chk("rst_dout", 128'(d32), 128'(0));
    @(negedge clock); reset = 1'b0;

    run32("neg3x5",  32'hFFFF_FFFD, 32'd5,        1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 6);
    run32("uu_max",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, 6);
    run32("ss_m1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001, 6);
    run32("su_mix",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001, 6);
    run32("min_sq",  32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000, 6);
    run32("uu_ffff", 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b0, 64'h0000_0000_FFFE_0001, 6);

    // Backpressure test: hold the result in DONE and ignore new requests.
    out_ready = 1'b0;
    accept32(32'h10, 32'h20, 1'b0, 1'b0, lat);
    chk("bp_lat", 128'(lat), 128'(6));
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      iv32 = 1'b1; a32 = 32'h1234 + k; b32 = 32'h77; a_signed = 1'b1;
      @(posedge clock); #1;
      chk("bp_valid", 128'(ov32), 128'(1));
      chk("bp_dout", 128'(d32), 128'(64'h200));
      chk("bp_ready", 128'(ir32), 128'(0));
    end
    @(negedge clock);
    iv32 = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    chk("bp_release", 128'({ov32, ir32}), 128'(2'b01));
    run32("bp_next", 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 6);

    // Reset in the middle of MUL drops the transaction.
    @(negedge clock);
    a32 = 32'h1234_5678; b32 = 32'h9; a_signed = 1'b0; b_signed = 1'b0; iv32 = 1'b1;
    @(posedge clock); #1;
    iv32 = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid_rst", 128'({ov32, ir32}), 128'(2'b01));
    chk("mid_rst_dout", 128'(d32), 128'(0));
    @(negedge clock); reset = 1'b0;
    run32("after_rst", 32'd7, 32'd9, 1'b0, 1'b0, 64'd63, 6);

`ifdef MUL_WIDE_SEQ_ZERO_SKIP_EN
    zlat = 2;
`else
    zlat = 6;
`endif
    run32("zero", 32'h0, 32'h1234_5678, 1'b0, 1'b0, 64'h0, zlat);

    // WIDTH=16: -3 * 5, which has a latency of 3.
    @(negedge clock);
    a16 = 16'hFFFD; b16 = 16'd5; a_signed = 1'b1; b_signed = 1'b1; iv16 = 1'b1;
    @(posedge clock); #1;
    iv16 = 1'b0;
    lat = 1;
    while (!ov16 && lat < 200) begin @(posedge clock); #1; lat++; end
    chk("w16_lat", 128'(lat), 128'(3));
    chk("w16_dout", 128'(d16), 128'(32'hFFFF_FFF1));
    @(posedge clock); #1;

    // WIDTH=64: -3 * 5, which has a latency of 18.
    @(negedge clock);
    a64 = 64'hFFFF_FFFF_FFFF_FFFD; b64 = 64'd5; iv64 = 1'b1;
    @(posedge clock); #1;
    iv64 = 1'b0;
    lat = 1;
    while (!ov64 && lat < 200) begin @(posedge clock); #1; lat++; end
    chk("w64_lat", 128'(lat), 128'(18));
    chk("w64_dout", d64, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1);
    @(posedge clock); #1;
    chk("w64_idle", 128'({ov64, ir64}), 128'(2'b01));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
